// File: rtl/dbg_decode.sv
// dbg_decode: decode stage of the debug pipeline.
// Takes {pc, inst} pairs over valid/ready, decodes the RISC-V SYSTEM-class
// instructions into one-hot op flags and presents them registered to the
// execute stage. A one-entry skid buffer keeps in_ready purely registered.
// Once an ebreak has been handed downstream the stage halts until reset.
module dbg_decode #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic             ebreak_op,
    output logic             ecall_op,
    output logic             mret_op,
    output logic             wfi_op,
    output logic             illegal_op,
    output logic             halted,
    output logic [CNT_W-1:0] inst_count
);

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Op flag vectors are packed as {ebreak, ecall, mret, wfi, illegal}.
    localparam int OP_EBREAK  = 4;
    localparam int OP_ECALL   = 3;
    localparam int OP_MRET    = 2;
    localparam int OP_WFI     = 1;
    localparam int OP_ILLEGAL = 0;

    logic [4:0]  dec_ops;
    logic [4:0]  out_ops;
    logic        skid_valid;
    logic [63:0] skid_pc;
    logic [4:0]  skid_ops;
    logic        accept;
    logic        out_hs;

    // Skid slot and halt are both registers, so in_ready never depends on
    // anything combinational from downstream.
    assign in_ready = ~skid_valid & ~halted;
    assign accept   = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;

    assign ebreak_op  = out_ops[OP_EBREAK];
    assign ecall_op   = out_ops[OP_ECALL];
    assign mret_op    = out_ops[OP_MRET];
    assign wfi_op     = out_ops[OP_WFI];
    assign illegal_op = out_ops[OP_ILLEGAL];

    // Decode the incoming word into at most one op flag; any SYSTEM funct3=0
    // word that is not one of the four supported encodings is illegal.
    always_comb begin
        dec_ops = '0;
        if (in_inst == 32'h0000_0000 || in_inst == 32'hFFFF_FFFF ||
            in_inst[1:0] != 2'b11) begin
            dec_ops[OP_ILLEGAL] = 1'b1;
        end else if (in_inst[6:0] == OPC_SYSTEM && in_inst[14:12] == 3'b000) begin
            if (in_inst[11:7] == 5'd0 && in_inst[19:15] == 5'd0) begin
                case (in_inst[31:20])
                    12'h000: dec_ops[OP_ECALL]   = 1'b1;
                    12'h001: dec_ops[OP_EBREAK]  = 1'b1;
                    12'h302: dec_ops[OP_MRET]    = 1'b1;
                    12'h105: dec_ops[OP_WFI]     = 1'b1;
                    default: dec_ops[OP_ILLEGAL] = 1'b1;
                endcase
            end else begin
                dec_ops[OP_ILLEGAL] = 1'b1;
            end
        end
    end

    // OUT/SKID storage: refill OUT from SKID on a drain, otherwise load the
    // accepted instruction into OUT if it is free or draining, else into SKID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_ops    <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_ops   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_hs && skid_valid) begin
            out_valid  <= 1'b1;
            out_pc     <= skid_pc;
            out_ops    <= skid_ops;
            skid_valid <= 1'b0;
        end else if (accept && (!out_valid || out_hs)) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_ops   <= dec_ops;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_pc    <= in_pc;
            skid_ops   <= dec_ops;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky halt once an ebreak leaves the stage; flush cannot clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (out_hs && out_ops[OP_EBREAK]) begin
            halted <= 1'b1;
        end
    end

    // Count every output handshake, including one that coincides with flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_count <= '0;
        end else if (out_hs) begin
            inst_count <= inst_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dbg_decode.sv
// tb_dbg_decode: self-checking bench for dbg_decode.
// An in-order scoreboard queue (max two entries) stands in for the stage;
// a second instance with a 4-bit counter watches the wrap behaviour.
module tb_dbg_decode;

    localparam logic [4:0] F_NONE   = 5'b00000;
    localparam logic [4:0] F_EBREAK = 5'b10000;
    localparam logic [4:0] F_ECALL  = 5'b01000;
    localparam logic [4:0] F_MRET   = 5'b00100;
    localparam logic [4:0] F_WFI    = 5'b00010;
    localparam logic [4:0] F_ILL    = 5'b00001;

    localparam logic [31:0] ADDI = 32'h0010_0093;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  ops;
    } entry_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  exp_ops;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic        ebreak_op, ecall_op, mret_op, wfi_op, illegal_op;
    logic        halted;
    logic [31:0] inst_count;

    logic        in_ready4, out_valid4, halted4;
    logic [63:0] out_pc4;
    logic        ebreak4, ecall4, mret4, wfi4, illegal4;
    logic [3:0]  inst_count4;

    entry_t      sb[$];
    logic        m_halted;
    logic [31:0] m_count;
    int          n_checks;
    int          n_fail;
    vec_t        tbl[9];

    dbg_decode dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .ebreak_op(ebreak_op), .ecall_op(ecall_op), .mret_op(mret_op),
        .wfi_op(wfi_op), .illegal_op(illegal_op),
        .halted(halted), .inst_count(inst_count)
    );

    dbg_decode #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid4), .out_ready(out_ready), .out_pc(out_pc4),
        .ebreak_op(ebreak4), .ecall_op(ecall4), .mret_op(mret4),
        .wfi_op(wfi4), .illegal_op(illegal4),
        .halted(halted4), .inst_count(inst_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode straight from the instruction-word rules.
    function automatic logic [4:0] model_decode(input logic [31:0] w);
        if (w == 32'h0 || w == 32'hFFFF_FFFF || w[1:0] != 2'b11) return F_ILL;
        if (w[6:0] != 7'h73 || w[14:12] != 3'd0) return F_NONE;
        if (w == 32'h0000_0073) return F_ECALL;
        if (w == 32'h0010_0073) return F_EBREAK;
        if (w == 32'h3020_0073) return F_MRET;
        if (w == 32'h1050_0073) return F_WFI;
        return F_ILL;
    endfunction

    function automatic bit model_ready();
        return (sb.size() < 2) && !m_halted;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("in_ready", 64'(in_ready), 64'(model_ready()));
        check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
        if (sb.size() > 0) begin
            check("out_pc", out_pc, sb[0].pc);
            check("out_ops", 64'({ebreak_op, ecall_op, mret_op, wfi_op, illegal_op}),
                  64'(sb[0].ops));
        end
        check("halted", 64'(halted), 64'(m_halted));
        check("inst_count", 64'(inst_count), 64'(m_count));
        check("inst_count4", 64'(inst_count4), 64'(m_count[3:0]));
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                                 input logic [4:0] exp_ops, input logic ordy, input logic fl);
        bit acc;
        bit hs;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        checkOutput();
        acc = v && model_ready() && !fl;
        hs  = (sb.size() > 0) && ordy;
        if (hs) begin
            m_count++;
            if (sb[0].ops == F_EBREAK) m_halted = 1'b1;
            void'(sb.pop_front());
        end
        if (fl) sb.delete();
        else if (acc) sb.push_back('{pc, exp_ops});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 64'h0, 32'h0, F_NONE, ordy, 1'b0);
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        sb.delete();
        m_halted  = 1'b0;
        m_count   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_ops", 64'({ebreak_op, ecall_op, mret_op, wfi_op, illegal_op}), 64'h0);
        check("rst_halted", 64'(halted), 64'h0);
        check("rst_count", 64'(inst_count), 64'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic [63:0] pc;
        n_checks = 0;
        n_fail   = 0;

        tbl[0] = '{64'h3000, 32'h0000_0073, F_ECALL};
        tbl[1] = '{64'h3004, 32'h3020_0073, F_MRET};
        tbl[2] = '{64'h3008, 32'h1050_0073, F_WFI};
        tbl[3] = '{64'h300C, 32'h0000_0000, F_ILL};
        tbl[4] = '{64'h3010, 32'h0020_0073, F_ILL};
        tbl[5] = '{64'h3014, 32'hFFFF_FFFF, F_ILL};
        tbl[6] = '{64'h3018, 32'h0000_4501, F_ILL};
        tbl[7] = '{64'h301C, 32'h3400_1073, F_NONE};
        tbl[8] = '{64'h3020, ADDI,          F_NONE};

        doReset();
        $display("[TB] reset done");

        // Basic stream of addi at full throughput.
        applyStimulus(1'b1, 64'h1000, ADDI, F_NONE, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h1004, ADDI, F_NONE, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h1008, ADDI, F_NONE, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("count_after_addi", 64'(inst_count), 64'd3);

        // Decode table.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, tbl[i].pc, tbl[i].inst, tbl[i].exp_ops, 1'b1, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // Backpressure: OUT then SKID fill, third offer refused, then drain.
        applyStimulus(1'b1, 64'h4000, ADDI, F_NONE, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h4004, 32'h0000_0073, F_ECALL, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h4008, ADDI, F_NONE, 1'b0, 1'b0);
        check("skid_full_in_ready", 64'(in_ready), 64'h0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("drained_in_ready", 64'(in_ready), 64'h1);

        // Flush with OUT and SKID full and a live input.
        applyStimulus(1'b1, 64'h5000, ADDI, F_NONE, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h5004, ADDI, F_NONE, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h5008, 32'h1050_0073, F_WFI, 1'b0, 1'b1);
        check("flush_out_valid", 64'(out_valid), 64'h0);
        check("flush_in_ready", 64'(in_ready), 64'h1);
        idle(1'b1);

        // Flush coinciding with an output handshake still counts it.
        applyStimulus(1'b1, 64'h5100, ADDI, F_NONE, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 32'h0, F_NONE, 1'b1, 1'b1);
        idle(1'b1);

        // Randomized traffic (no ebreak so the stage keeps running).
        for (int i = 0; i < 400; i++) begin
            pc = {$urandom, $urandom} & ~64'h3;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    w = $urandom | 32'h3;
                    if (w[6:0] == 7'h73 && w[14:12] == 3'd0) w[14:12] = 3'd1;
                end
                5: w = 32'h0000_0073;
                6: w = 32'h3020_0073;
                7: w = 32'h1050_0073;
                8: w = ($urandom_range(0, 1) == 0) ? 32'h0020_0073 : 32'hFFFF_FFFF;
                default: w = $urandom & ~32'h1;
            endcase
            applyStimulus($urandom_range(0, 3) != 0, pc, w, model_decode(w),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset mid-transfer discards OUT and SKID immediately.
        applyStimulus(1'b1, 64'h6000, ADDI, F_NONE, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h6004, ADDI, F_NONE, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'h0);
        check("async_rst_in_ready", 64'(in_ready), 64'h1);
        check("async_rst_count", 64'(inst_count), 64'h0);
        doReset();

        // ebreak halts the stage; flush does not clear the halt.
        applyStimulus(1'b1, 64'h2000, 32'h0010_0073, F_EBREAK, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h2004, ADDI, F_NONE, 1'b1, 1'b0);
        check("halted_after_ebreak", 64'(halted), 64'h1);
        applyStimulus(1'b1, 64'h2008, ADDI, F_NONE, 1'b1, 1'b0);
        check("halted_in_ready", 64'(in_ready), 64'h0);
        applyStimulus(1'b1, 64'h200C, ADDI, F_NONE, 1'b1, 1'b1);
        idle(1'b1);
        check("halted_after_flush", 64'(halted), 64'h1);

        // Reset clears halt; 17 handshakes wrap the 4-bit counter to 1.
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 64'h7000 + 64'(4 * i), ADDI, F_NONE, 1'b1, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);
        check("count4_wrap", 64'(inst_count4), 64'd1);
        check("count32_17", 64'(inst_count), 64'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dbg_decode.md
# dbg_decode

Decode stage for the debug pipeline. Accepts fetched `{pc, inst}` pairs over a valid/ready handshake and decodes the RISC-V SYSTEM-class instructions. It presents registered `pc` and system-op flags to the debug execute stage; at top level these flags drive the `sys_ops` bundle consumed downstream. It also owns the pipeline halt: once an `ebreak` has been handed downstream, no further instructions are accepted.

## Interface
Parameters:
- `CNT_W`, 32: width of the decoded-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous flush of the stage contents.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept an instruction.
- `in_pc`  in  64  pc of the incoming instruction.
- `in_inst`  in  32  raw instruction word.
- `out_valid`  out  1  decoded instruction is available.
- `out_ready`  in  1  execute stage accepts it.
- `out_pc`  out  64  pc of the decoded instruction.
- `ebreak_op`  out  1  decoded instruction is `ebreak`.
- `ecall_op`  out  1  decoded instruction is `ecall`.
- `mret_op`  out  1  decoded instruction is `mret`.
- `wfi_op`  out  1  decoded instruction is `wfi`.
- `illegal_op`  out  1  decoded instruction is illegal.
- `halted`  out  1  sticky; set once an `ebreak` has been handed downstream.
- `inst_count`  out  `CNT_W`  count of output handshakes.

## Operation
- Storage: an output register (OUT) plus a one-entry skid buffer (SKID). Each holds `valid`, `pc` and the five op flags.
- `in_ready = ~skid_valid & ~halted`. It is driven only from registers.
- Input accept: when `in_valid & in_ready`, decode `in_inst`.
  - If OUT is empty, or is being drained in the same cycle (`out_valid & out_ready`), load OUT.
  - Otherwise load SKID.
- On an output handshake with SKID valid: SKID moves to OUT and SKID clears. A new input accept in that same cycle is impossible, because `in_ready` is 0 while SKID is valid.
- Decode rules (combinational, on the input side):
  - SYSTEM means `inst[6:0]=7'b1110011`, `funct3=0`, `rd=0`, `rs1=0`.
  - SYSTEM with `imm[11:0]` = `0x000` → ecall; `0x001` → ebreak; `0x302` → mret; `0x105` → wfi.
  - Any other SYSTEM `funct3=0` encoding → illegal.
  - Also illegal: `inst=32'h0`, `inst=32'hFFFFFFFF`, or `inst[1:0]!=2'b11` (no compressed support).
  - Everything else is a normal instruction: all flags 0.
  - At most one flag is set per instruction.
- Halt:
  - `halted` sets on the output handshake of an instruction with `ebreak_op=1`. From that point `in_ready=0`.
  - Only reset clears `halted`; `flush` does not.
- Flush:
  - Clears OUT and SKID valid.
  - Has priority over an input accept and an output move in the same cycle.
  - `inst_count` still counts an output handshake that coincides with the flush.
- Counter: `inst_count` increments on every `out_valid & out_ready` and wraps modulo 2^`CNT_W`.

## Timing
- Reset values:
  - `out_valid=0`, `out_pc=0`, all op flags 0.
  - `halted=0`, `inst_count=0`.
  - SKID empty, so `in_ready=1` once out of reset.
- Latency: an instruction accepted in cycle N has `out_valid=1` in cycle N+1.
- Throughput: one instruction per cycle while `out_ready=1`.
- Backpressure:
  - When OUT is held, one more instruction is absorbed into SKID.
  - `in_ready` drops in the cycle after that absorb.
  - No instruction is dropped or duplicated.
- OUT contents are stable while `out_valid & ~out_ready`.
- An assertion of `rst_n` mid-transfer discards OUT and SKID immediately (asynchronous).
- The counter wraps from `2^CNT_W-1` to 0 with no flag.

## Test plan
- Reset, then stream `addi` words at pc `0x1000, 0x1004, 0x1008` with `out_ready=1` → each appears one cycle later with all flags 0; `inst_count=3`.
- `inst=0x00100073` at pc `0x2000` → `ebreak_op=1`, `out_pc=0x2000`. After the handshake `halted=1` and `in_ready=0` even with `in_valid` held high. A subsequent `flush` leaves `halted=1`.
- `0x00000073`, `0x30200073`, `0x10500073`, `0x00000000`, `0x00200073` → ecall, mret, wfi, illegal, illegal respectively.
- Hold `out_ready=0` while sending two instructions → first in OUT, second in SKID, `in_ready=0`. Release `out_ready` → both emerge in order on consecutive cycles and `in_ready` returns to 1.
- Assert `flush` with OUT and SKID full and `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, and the flush-cycle input is not captured.
- Run with `CNT_W=4` and 17 handshakes → `inst_count=1`.
